// File: rtl/cga_vram_fetch_if.sv
// VRAM read port and character-cell stream between the fetch sequencer and its neighbours.
interface cga_vram_fetch_if #(
  parameter int ADDR_W = 14
);
  logic              vram_en;
  logic [ADDR_W:0]   vram_addr;
  logic [7:0]        vram_din;
  logic              cell_valid;
  logic              cell_ready;
  logic [7:0]        cell_char;
  logic [7:0]        cell_attr;

  modport master (
    output vram_en, vram_addr, cell_valid, cell_char, cell_attr,
    input  vram_din, cell_ready
  );

  modport slave (
    input  vram_en, vram_addr, cell_valid, cell_char, cell_attr,
    output vram_din, cell_ready
  );
endinterface

// File: rtl/cga_vram_fetch.sv
// Per-line VRAM read sequencer: fetches char/attr byte pairs into a FWFT cell FIFO.
// IDLE: no line | RD_CHAR: read char byte | RD_ATTR: read attr byte | CAP_ATTR: push cell | WAIT: FIFO full
module cga_vram_fetch #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [7:0]        cells,
  output logic              busy,
  output logic              line_done,
  cga_vram_fetch_if.master  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_CHAR  = 3'd1;
  localparam logic [2:0] RD_ATTR  = 3'd2;
  localparam logic [2:0] CAP_ATTR = 3'd3;
  localparam logic [2:0] WAIT     = 3'd4;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_TWO = ADDR_W'(2);
  localparam logic [PW:0]       CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]       CNT_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0]     PTR_ONE  = PW'(1);

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_last_q, rd_addr, start_even;
  logic [7:0]        n_q, char_q;
  logic              zero_done_q;
  logic              vram_en, abort, push, pop, fifo_empty;

  logic [15:0]       mem [FIFO_DEPTH];
  logic [15:0]       hold_q, head;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count, count_nxt;

  assign start_even = {start_addr[ADDR_W-1:1], 1'b0};
  assign busy       = (state != IDLE);
  assign abort      = line_start && busy;
  assign fifo_empty = (count == '0);
  assign pop        = !fifo_empty && bus.cell_ready;
  // the cell being captured when a new line starts belongs to the aborted line
  assign push       = (state == CAP_ATTR) && !line_start;
  assign line_done  = zero_done_q || (push && (n_q == 8'd1));

  assign vram_en        = (state == RD_CHAR) || (state == RD_ATTR);
  assign rd_addr        = (state == RD_ATTR) ? addr_q + ADDR_ONE : addr_q;
  assign bus.vram_en    = vram_en;
  assign bus.vram_addr  = {1'b0, vram_en ? rd_addr : addr_last_q};

  assign head           = fifo_empty ? hold_q : mem[rd_ptr];
  assign bus.cell_valid = !fifo_empty;
  assign bus.cell_char  = head[7:0];
  assign bus.cell_attr  = head[15:8];

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CNT_ONE;
    else if (!push && pop)
      count_nxt = count - CNT_ONE;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = IDLE;
      RD_CHAR:  state_nxt = RD_ATTR;
      RD_ATTR:  state_nxt = CAP_ATTR;
      CAP_ATTR: begin
        if (n_q == 8'd1)
          state_nxt = IDLE;
        else if (count_nxt < CNT_FULL)
          state_nxt = RD_CHAR;
        else
          state_nxt = WAIT;
      end
      WAIT:     if (count_nxt < CNT_FULL) state_nxt = RD_CHAR;
      default:  state_nxt = IDLE;
    endcase
    if (line_start)
      state_nxt = (cells == 8'd0) ? IDLE : RD_CHAR;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      addr_last_q <= '0;
      n_q         <= '0;
      char_q      <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      zero_done_q <= line_start && (cells == 8'd0);
      if (line_start) begin
        addr_q <= start_even;
        n_q    <= cells;
      end else if (push) begin
        addr_q <= addr_q + ADDR_TWO;
        n_q    <= n_q - 8'd1;
      end
      if (vram_en)
        addr_last_q <= rd_addr;
      if (state == RD_ATTR)
        char_q <= bus.vram_din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
    end else begin
      if (!fifo_empty)
        hold_q <= mem[rd_ptr];
      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= {bus.vram_din, char_q};
          wr_ptr      <= wr_ptr + PTR_ONE;
        end
        if (pop)
          rd_ptr <= rd_ptr + PTR_ONE;
        count <= count_nxt;
      end
    end
  end
endmodule

// File: doc/cga_vram_fetch.md
Name: cga_vram_fetch

Overview:
Read-side sequencer for the 16 KB dual-port video RAM: on each display line it reads character/attribute byte pairs from one RAM port and queues them for the pixel/character-generator pipeline. It drives the RAM read port (enable, address; write enable tied low externally) and presents cells through a first-word-fall-through FIFO with a valid/ready handshake. It owns RAM read timing and address wrap, so the CRTC only supplies a start address and a cell count.

Parameters:
FIFO_DEPTH, 4, cell FIFO entries (power of two, ≥2)
ADDR_W, 14, VRAM byte-address width; addresses wrap modulo 2^ADDR_W

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
line_start  in  1  one-cycle pulse: begin fetching a new line
start_addr  in  14  byte address of first character of the line (must be even; bit 0 is ignored and treated as 0)
cells  in  8  number of cells to fetch (0 = none)
vram_en  out  1  RAM read enable
vram_addr  out  15  RAM byte address; bit 14 always 0
vram_din  in  8  RAM read data, registered, valid the cycle after vram_en
cell_valid  out  1  FIFO head holds a cell
cell_ready  in  1  consumer accepts head this cycle
cell_char  out  8  character byte of head cell
cell_attr  out  8  attribute byte of head cell
busy  out  1  line fetch in progress (state ≠ IDLE)
line_done  out  1  one-cycle pulse when the last cell of a line is pushed

Behaviour:
- Reset (async, reset_n=0): state IDLE; FIFO empty. vram_en=0, vram_addr=0, cell_valid=0, cell_char=0, cell_attr=0, busy=0, line_done=0.
- States: IDLE, RD_CHAR, RD_ATTR, CAP_ATTR, WAIT.
- IDLE: on line_start, latch A = {start_addr[13:1],0} and N = cells. If N=0, stay IDLE and pulse line_done the next cycle. Otherwise go to RD_CHAR.
- RD_CHAR (cycle t): vram_en=1, vram_addr={0,A}. Next state: RD_ATTR.
- RD_ATTR (t+1): vram_en=1, vram_addr={0,(A+1) mod 2^ADDR_W}. Capture vram_din as the character byte at the end of the cycle.
- CAP_ATTR (t+2): vram_en=0. vram_din is the attribute byte. Push {attr,char} into the FIFO at the end of the cycle. Update N←N−1 and A←(A+2) mod 2^ADDR_W.
- Next state after CAP_ATTR:
  - If N becomes 0: go to IDLE and assert line_done in that same cycle.
  - Otherwise, compute next FIFO count, including this cycle's push and any pop. If it is < FIFO_DEPTH, go to RD_CHAR; else go to WAIT.
- WAIT: vram_en=0. Go to RD_CHAR once FIFO count < FIFO_DEPTH.
- Throughput: 3 cycles per cell when the consumer keeps up. At most one cell is in flight. The design must never push into a full FIFO.
- vram_addr holds its last value when vram_en=0.
- FIFO:
  - cell_valid = not empty.
  - cell_char/cell_attr show the head entry combinationally from storage. They hold their last value when empty (0 after reset).
  - A pop happens when cell_valid && cell_ready. Push and pop in the same cycle are both allowed; the count is unchanged.
  - cell_ready while empty is ignored.
- Wrap-around: A=0x3FFE fetches char at 0x3FFE and attr at 0x3FFF, then A=0x0000. The design must handle all wrap cases exactly as modulo arithmetic.
- line_start while busy (abort and restart):
  - At the end of that cycle, flush the FIFO (cell_valid=0 next cycle) and discard any in-flight bytes (no push from the aborted cell).
  - Reload A and N; the next state is RD_CHAR, or IDLE with a line_done pulse if cells=0.
  - The aborted line produces no line_done. A flush overrides a simultaneous pop.
- line_start coinciding with the CAP_ATTR of the final cell: the abort wins. No push and no line_done for the old line.

Test Plan:
- Basic line: RAM[0x0100..0x0105]=41,07,42,1F,43,70; line_start start_addr=0x0100 cells=3, cell_ready=1 -> cells (41,07),(42,1F),(43,70) in order. vram_en high on exactly 6 cycles with addresses 0x100..0x105. line_done pulses once, 9 cycles after line_start.
- Backpressure: cells=8, cell_ready=0 -> exactly 4 cells queued, FSM parks in WAIT, vram_en=0. Release ready -> all 8 cells delivered in order, no duplicates or losses.
- Wrap: start_addr=0x3FFC cells=3 -> reads at 0x3FFC,0x3FFD,0x3FFE,0x3FFF,0x0000,0x0001. vram_addr[14]=0 throughout.
- Abort: line_start(0x0200, cells=80), then line_start(0x0400, cells=2) 5 cycles later -> FIFO empty next cycle. Only the 2 cells from 0x0400 are delivered. A single line_done is seen.
- Zero cells: line_start cells=0 -> no vram_en, line_done pulses 1 cycle later, busy stays 0.
- Reset mid-line: reset_n low during RD_ATTR -> all outputs 0 immediately. After release, idle until the next line_start.
